// File: rtl/dst_reg_sel_pipe.sv
// Destination-register select and carry pipeline.
// Picks the ID-stage destination index from NUM_IN candidates, carries it with a
// write-valid bit through DEPTH stages, and flags the youngest stage whose carried
// destination matches the ID source registers rs / rt.
module dst_reg_sel_pipe #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned NUM_IN = 3,
    // 2**SEL_W must cover NUM_IN
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned DEPTH  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    hold,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        rs,
    input  logic [WIDTH-1:0]        rt,
    output logic [DEPTH*WIDTH-1:0]  dst_q,
    output logic [DEPTH-1:0]        dst_v,
    output logic [DEPTH-1:0]        fwd_rs,
    output logic [DEPTH-1:0]        fwd_rt,
    output logic                    sel_err
);

    logic [WIDTH-1:0] cand;
    logic             cand_v;

    logic [WIDTH-1:0] stage_idx_q [DEPTH];
    logic [WIDTH-1:0] stage_idx_d [DEPTH];
    logic [DEPTH-1:0] stage_v_q;
    logic [DEPTH-1:0] stage_v_d;

    logic [DEPTH-1:0] raw_rs;
    logic [DEPTH-1:0] raw_rt;

    assign sel_err = (32'(sel) >= NUM_IN);

    // Candidate mux; out-of-range selects fall through to index 0.
    always_comb begin
        cand = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (32'(sel) == k) begin
                cand = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    // $0 is never a real write, so a zero index can never be valid.
    assign cand_v = in_valid && !sel_err && (cand != '0);

    // Next-state: hold freezes the shift, flush injects a bubble into stage 0.
    always_comb begin
        stage_idx_d = stage_idx_q;
        stage_v_d   = stage_v_q;
        if (!hold) begin
            for (int unsigned s = 1; s < DEPTH; s++) begin
                stage_idx_d[s] = stage_idx_q[s-1];
                stage_v_d[s]   = stage_v_q[s-1];
            end
        end
        if (flush) begin
            stage_idx_d[0] = '0;
            stage_v_d[0]   = 1'b0;
        end else if (!hold) begin
            // Bubbles carry index 0 so a stale index is never visible.
            stage_idx_d[0] = cand_v ? cand : '0;
            stage_v_d[0]   = cand_v;
        end
    end

    // Stage registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                stage_idx_q[s] <= '0;
            end
            stage_v_q <= '0;
        end else begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                stage_idx_q[s] <= stage_idx_d[s];
            end
            stage_v_q <= stage_v_d;
        end
    end

    // Flatten the stage array onto the output bus.
    always_comb begin
        dst_q = '0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            dst_q[s*WIDTH +: WIDTH] = stage_idx_q[s];
        end
    end

    assign dst_v = stage_v_q;

    // Raw per-stage matches against the ID sources, registered state only.
    always_comb begin
        raw_rs = '0;
        raw_rt = '0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            raw_rs[s] = stage_v_q[s] && (stage_idx_q[s] == rs) && (rs != '0);
            raw_rt[s] = stage_v_q[s] && (stage_idx_q[s] == rt) && (rt != '0);
        end
    end

    // Keep only the lowest set bit: stage 0 is the youngest producer.
    assign fwd_rs = raw_rs & (~raw_rs + DEPTH'(1));
    assign fwd_rt = raw_rt & (~raw_rt + DEPTH'(1));

endmodule

// File: tb/tb_dst_reg_sel_pipe.sv
// Self-checking bench for dst_reg_sel_pipe: directed scenarios plus a random
// stream compared against a stage-list reference model.
module tb_dst_reg_sel_pipe;

    localparam int W = 5;
    localparam int N = 3;
    localparam int SW = 2;
    localparam int D = 3;

    logic            clk;
    logic            rst;
    logic [N*W-1:0]  in_bus;
    logic [SW-1:0]   sel;
    logic            in_valid;
    logic            hold;
    logic            flush;
    logic [W-1:0]    rs;
    logic [W-1:0]    rt;
    logic [D*W-1:0]  dst_q;
    logic [D-1:0]    dst_v;
    logic [D-1:0]    fwd_rs;
    logic [D-1:0]    fwd_rt;
    logic            sel_err;

    int checks;
    int failures;

    // Reference model: list of stages, youngest first
    int m_idx [D];
    bit m_v   [D];
    int slot  [N];

    dst_reg_sel_pipe #(
        .WIDTH  (W),
        .NUM_IN (N),
        .SEL_W  (SW),
        .DEPTH  (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_bus   (in_bus),
        .sel      (sel),
        .in_valid (in_valid),
        .hold     (hold),
        .flush    (flush),
        .rs       (rs),
        .rt       (rt),
        .dst_q    (dst_q),
        .dst_v    (dst_v),
        .fwd_rs   (fwd_rs),
        .fwd_rt   (fwd_rt),
        .sel_err  (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_slots(input int a, input int b, input int c);
        slot[0] = a;
        slot[1] = b;
        slot[2] = c;
        in_bus = {W'(c), W'(b), W'(a)};
    endtask

    task automatic model_clear();
        for (int s = 0; s < D; s++) begin
            m_idx[s] = 0;
            m_v[s] = 0;
        end
    endtask

    // One rising edge; the model applies the edge rules to the inputs it saw.
    task automatic tick();
        int cand;
        bit cv;
        @(posedge clk);
        cand = (int'(sel) < N) ? slot[sel] : 0;
        cv = in_valid && (int'(sel) < N) && (cand != 0);
        if (!(hold && !flush)) begin
            if (!hold) begin
                for (int s = D - 1; s >= 1; s--) begin
                    m_idx[s] = m_idx[s-1];
                    m_v[s] = m_v[s-1];
                end
            end
            if (flush || !cv) begin
                m_idx[0] = 0;
                m_v[0] = 0;
            end else begin
                m_idx[0] = cand;
                m_v[0] = 1;
            end
        end
        #1;
    endtask

    function automatic logic [D*W-1:0] exp_q();
        logic [D*W-1:0] r;
        for (int s = 0; s < D; s++) r[s*W +: W] = W'(m_idx[s]);
        return r;
    endfunction

    function automatic logic [D-1:0] exp_v();
        logic [D-1:0] r;
        for (int s = 0; s < D; s++) r[s] = m_v[s];
        return r;
    endfunction

    function automatic logic [D-1:0] exp_fwd(input int r);
        if (r == 0) return '0;
        for (int s = 0; s < D; s++) begin
            if (m_v[s] && m_idx[s] == r) return D'(1 << s);
        end
        return '0;
    endfunction

    task automatic load(input int v);
        set_slots(v, 0, 0);
        sel = 0;
        in_valid = 1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1;
        #2;
        checks++;
        if (dst_q !== '0 || dst_v !== '0) begin
            failures++;
            $display("FAIL reset_hold: dst_q=%h dst_v=%b required 0/0", dst_q, dst_v);
        end
        #5;
        rst = 0;
        model_clear();
        #1;
        checks++;
        if (dst_q !== '0 || dst_v !== '0 || fwd_rs !== '0 || fwd_rt !== '0) begin
            failures++;
            $display("FAIL reset_release: dst_q=%h dst_v=%b fwd=%b/%b required 0",
                     dst_q, dst_v, fwd_rs, fwd_rt);
        end
    endtask

    task automatic test_reset_mid();
        load(3);
        load(12);
        load(21);
        rs = 12;
        rt = 21;
        #1;
        checks++;
        if (dst_v !== 3'b111) begin
            failures++;
            $display("FAIL mid_fill: dst_v=%b required 111", dst_v);
        end
        #2;
        rst = 1;
        #1;
        checks++;
        if (dst_q !== '0 || dst_v !== '0 || fwd_rs !== '0 || fwd_rt !== '0) begin
            failures++;
            $display("FAIL mid_reset: dst_q=%h dst_v=%b fwd=%b/%b required 0",
                     dst_q, dst_v, fwd_rs, fwd_rt);
        end
        rst = 0;
        model_clear();
        in_valid = 0;
    endtask

    task automatic test_propagation();
        set_slots(5, 9, 31);
        sel = 2;
        in_valid = 1;
        tick();
        checks++;
        if (dst_q !== {5'd0, 5'd0, 5'd31} || dst_v !== 3'b001) begin
            failures++;
            $display("FAIL prop_s0: dst_q=%h dst_v=%b required %h/001",
                     dst_q, dst_v, {5'd0, 5'd0, 5'd31});
        end
        in_valid = 0;
        tick();
        checks++;
        if (dst_q !== {5'd0, 5'd31, 5'd0} || dst_v !== 3'b010) begin
            failures++;
            $display("FAIL prop_s1: dst_q=%h dst_v=%b required %h/010",
                     dst_q, dst_v, {5'd0, 5'd31, 5'd0});
        end
        tick();
        checks++;
        if (dst_q !== {5'd31, 5'd0, 5'd0} || dst_v !== 3'b100) begin
            failures++;
            $display("FAIL prop_s2: dst_q=%h dst_v=%b required %h/100",
                     dst_q, dst_v, {5'd31, 5'd0, 5'd0});
        end
        tick();
        checks++;
        if (dst_q !== '0 || dst_v !== '0) begin
            failures++;
            $display("FAIL prop_drain: dst_q=%h dst_v=%b required 0/000", dst_q, dst_v);
        end
    endtask

    task automatic test_zero_and_range();
        set_slots(0, 9, 31);
        sel = 0;
        in_valid = 1;
        tick();
        checks++;
        if (dst_v[0] !== 1'b0 || dst_q[W-1:0] !== '0) begin
            failures++;
            $display("FAIL zero_reg: s0=%0d v=%b required 0/0", dst_q[W-1:0], dst_v[0]);
        end
        sel = 3;
        #1;
        checks++;
        if (sel_err !== 1'b1) begin
            failures++;
            $display("FAIL sel_err_hi: sel_err=%b required 1", sel_err);
        end
        tick();
        checks++;
        if (dst_v[0] !== 1'b0 || dst_q[W-1:0] !== '0) begin
            failures++;
            $display("FAIL sel_range: s0=%0d v=%b required 0/0", dst_q[W-1:0], dst_v[0]);
        end
        sel = 1;
        #1;
        checks++;
        if (sel_err !== 1'b0) begin
            failures++;
            $display("FAIL sel_err_lo: sel_err=%b required 0", sel_err);
        end
    endtask

    task automatic test_forwarding();
        load(4);
        load(7);
        load(7);
        in_valid = 0;
        rs = 7;
        rt = 4;
        #1;
        checks++;
        if (fwd_rs !== 3'b001 || fwd_rt !== 3'b100) begin
            failures++;
            $display("FAIL fwd_prio: fwd_rs=%b fwd_rt=%b required 001/100", fwd_rs, fwd_rt);
        end
        rs = 0;
        rt = 7;
        #1;
        checks++;
        if (fwd_rs !== 3'b000 || fwd_rt !== 3'b001) begin
            failures++;
            $display("FAIL fwd_zero: fwd_rs=%b fwd_rt=%b required 000/001", fwd_rs, fwd_rt);
        end
        rs = 7;
        #1;
        checks++;
        if (fwd_rs !== fwd_rt || fwd_rs !== 3'b001) begin
            failures++;
            $display("FAIL fwd_same: fwd_rs=%b fwd_rt=%b required 001/001", fwd_rs, fwd_rt);
        end
    endtask

    task automatic test_hold_flush();
        load(9);
        load(8);
        load(7);
        set_slots(0, 17, 0);
        sel = 1;
        hold = 1;
        tick();
        tick();
        checks++;
        if (dst_q !== {5'd9, 5'd8, 5'd7} || dst_v !== 3'b111) begin
            failures++;
            $display("FAIL hold: dst_q=%h dst_v=%b required %h/111",
                     dst_q, dst_v, {5'd9, 5'd8, 5'd7});
        end
        flush = 1;
        tick();
        checks++;
        if (dst_q !== {5'd9, 5'd8, 5'd0} || dst_v !== 3'b110) begin
            failures++;
            $display("FAIL hold_flush: dst_q=%h dst_v=%b required %h/110",
                     dst_q, dst_v, {5'd9, 5'd8, 5'd0});
        end
        hold = 0;
        tick();
        checks++;
        if (dst_q !== {5'd8, 5'd0, 5'd0} || dst_v !== 3'b100) begin
            failures++;
            $display("FAIL flush: dst_q=%h dst_v=%b required %h/100",
                     dst_q, dst_v, {5'd8, 5'd0, 5'd0});
        end
        flush = 0;
        in_valid = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1000; c++) begin
            set_slots($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            sel = SW'($urandom_range(0, 3));
            in_valid = ($urandom_range(0, 9) < 8);
            hold = ($urandom_range(0, 9) < 2);
            flush = ($urandom_range(0, 9) < 2);
            rs = W'($urandom_range(0, 7));
            rt = W'($urandom_range(0, 7));
            #1;
            checks++;
            if (sel_err !== (int'(sel) >= N) || fwd_rs !== exp_fwd(rs)
                || fwd_rt !== exp_fwd(rt)) begin
                failures++;
                $display("FAIL rand_comb c=%0d: sel_err=%b fwd=%b/%b required %b %b/%b",
                         c, sel_err, fwd_rs, fwd_rt, int'(sel) >= N,
                         exp_fwd(rs), exp_fwd(rt));
            end
            tick();
            checks++;
            if (dst_q !== exp_q() || dst_v !== exp_v()) begin
                failures++;
                $display("FAIL rand_pipe c=%0d: dst_q=%h dst_v=%b required %h/%b",
                         c, dst_q, dst_v, exp_q(), exp_v());
            end
            for (int s = 0; s < D; s++) begin
                checks++;
                if (dst_v[s] === 1'b0 && dst_q[s*W +: W] !== '0) begin
                    failures++;
                    $display("FAIL rand_bubble c=%0d s=%0d: idx=%0d required 0",
                             c, s, dst_q[s*W +: W]);
                end
            end
        end
        hold = 0;
        flush = 0;
        in_valid = 0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        set_slots(0, 0, 0);
        sel = 0;
        in_valid = 0;
        hold = 0;
        flush = 0;
        rs = 0;
        rt = 0;
        model_clear();
        test_reset();
        test_reset_mid();
        test_propagation();
        test_zero_and_range();
        test_forwarding();
        test_hold_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
